// File: rtl/clkgen_reset_seq.sv
// PLL reset/lock supervisor: pulses pll_rst, filters lock, releases domain resets in a stagger.
// Define CLKGEN_LOCKLOSS_CNT_EN to build the saturating lock_lost_cnt; otherwise the port reads 0.
module clkgen_reset_seq #(
    parameter int NUM_DOMAINS = 3,
    parameter int LOCK_FILTER = 1024,
    parameter int STAGGER     = 16,
    parameter int RST_PULSE   = 8,
    parameter int TIMEOUT     = 1048576,
    parameter int MAX_RETRY   = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   force_relock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic                   fail,
    output logic [7:0]             lock_lost_cnt
);
    localparam int SMAX = (NUM_DOMAINS - 1) * STAGGER;
    localparam int PW   = $clog2(RST_PULSE) + 1;
    localparam int FW   = $clog2(LOCK_FILTER) + 1;
    localparam int TW   = $clog2(TIMEOUT) + 1;
    localparam int SW   = $clog2(SMAX) + 1;
    localparam int RW   = $clog2(MAX_RETRY) + 1;

    typedef enum logic [2:0] {PLLRST, WAIT_LOCK, RELEASE, RUN, FAILED} state_t;

    state_t                 state, state_next;
    logic [PW-1:0]          pulse_cnt, pulse_next;
    logic [FW-1:0]          filter_cnt, filter_next;
    logic [TW-1:0]          timeout_cnt, timeout_next;
    logic [SW-1:0]          stagger_cnt, stagger_next;
    logic [RW-1:0]          retry, retry_next;
    logic [NUM_DOMAINS-1:0] dom_next;
    logic                   sync_ff, lock_s;

    always_comb begin
        state_next   = state;
        pulse_next   = '0;
        filter_next  = '0;
        timeout_next = '0;
        stagger_next = '0;
        retry_next   = retry;
        case (state)
            PLLRST: begin
                if (pulse_cnt == PW'(RST_PULSE - 1))
                    state_next = WAIT_LOCK;
                else
                    pulse_next = pulse_cnt + PW'(1);
            end
            WAIT_LOCK: begin
                filter_next  = lock_s ? filter_cnt + FW'(1) : '0;
                timeout_next = timeout_cnt + TW'(1);
                // A completed filter takes priority over a timeout landing on the same cycle
                if (filter_next == FW'(LOCK_FILTER)) begin
                    state_next   = RELEASE;
                    filter_next  = '0;
                    timeout_next = '0;
                end else if (timeout_next == TW'(TIMEOUT)) begin
                    filter_next  = '0;
                    timeout_next = '0;
                    if (retry == RW'(MAX_RETRY)) begin
                        state_next = FAILED;
                    end else begin
                        retry_next = retry + RW'(1);
                        state_next = PLLRST;
                    end
                end
            end
            RELEASE, RUN: begin
                if (!lock_s || force_relock) begin
                    state_next = PLLRST;
                end else if (state == RELEASE) begin
                    if (stagger_cnt == SW'(SMAX)) begin
                        state_next = RUN;
                        retry_next = '0;
                    end else begin
                        stagger_next = stagger_cnt + SW'(1);
                    end
                end
            end
            FAILED: begin
                state_next = FAILED;
            end
            default: begin
                state_next = PLLRST;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        dom_next = '1;
        for (int i = 0; i < NUM_DOMAINS; i++)
            dom_next[i] = (state_next == RELEASE) ? (stagger_next < SW'(i * STAGGER))
                                                  : (state_next != RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= PLLRST;
            pulse_cnt   <= '0;
            filter_cnt  <= '0;
            timeout_cnt <= '0;
            stagger_cnt <= '0;
            retry       <= '0;
            sync_ff     <= 1'b0;
            lock_s      <= 1'b0;
            pll_rst     <= 1'b1;
            domain_rst  <= '1;
            all_ready   <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            pulse_cnt   <= pulse_next;
            filter_cnt  <= filter_next;
            timeout_cnt <= timeout_next;
            stagger_cnt <= stagger_next;
            retry       <= retry_next;
            sync_ff     <= pll_locked;
            lock_s      <= sync_ff;
            pll_rst     <= (state_next == PLLRST);
            domain_rst  <= dom_next;
            all_ready   <= (state_next == RUN);
            fail        <= (state_next == FAILED);
        end
    end

`ifdef CLKGEN_LOCKLOSS_CNT_EN
    logic [7:0] lost_q;
    logic       loss_event;

    // A forced relock coinciding with a real loss still counts exactly once
    assign loss_event = (state == RELEASE || state == RUN) && !lock_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            lost_q <= '0;
        else if (loss_event && lost_q != 8'hFF)
            lost_q <= lost_q + 8'd1;
    end

    assign lock_lost_cnt = lost_q;
`else
    assign lock_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clkgen_reset_seq.sv
// Self-checking bench for clkgen_reset_seq: directed scenarios plus randomized lock/relock traffic.
// Compile both files with CLKGEN_LOCKLOSS_CNT_EN defined to expect a live lock_lost_cnt.
module tb_clkgen_reset_seq;
    localparam int NUM_DOMAINS = 3;
    localparam int LOCK_FILTER = 8;
    localparam int STAGGER     = 4;
    localparam int RST_PULSE   = 4;
    localparam int TIMEOUT     = 64;
    localparam int MAX_RETRY   = 2;
`ifdef CLKGEN_LOCKLOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [13:0] RESET_VAL = {1'b1, 3'b111, 1'b0, 1'b0, 8'd0};

    localparam int PH_RST = 0, PH_WAIT = 1, PH_REL = 2, PH_RUN = 3, PH_FAIL = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   pll_locked = 1'b0;
    logic                   force_relock = 1'b0;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst;
    logic                   all_ready;
    logic                   fail;
    logic [7:0]             lock_lost_cnt;
    logic [13:0]            obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase, cycles spent in phase, consecutive synced-high run, retries, losses
    int m_phase, m_el, m_run, m_retry, m_lost;
    int hist[$];

    clkgen_reset_seq #(
        .NUM_DOMAINS(NUM_DOMAINS), .LOCK_FILTER(LOCK_FILTER), .STAGGER(STAGGER),
        .RST_PULSE(RST_PULSE), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clock(clock), .reset(reset), .pll_locked(pll_locked), .force_relock(force_relock),
        .pll_rst(pll_rst), .domain_rst(domain_rst), .all_ready(all_ready), .fail(fail),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clock = ~clock;

    assign obs = {pll_rst, domain_rst, all_ready, fail, lock_lost_cnt};

    task automatic model_reset();
        hist = '{0, 0};
        m_phase = PH_RST;
        m_el = 0;
        m_run = 0;
        m_retry = 0;
        m_lost = 0;
    endtask

    task automatic model_enter(input int p);
        m_phase = p;
        m_el = 0;
        m_run = 0;
    endtask

    // Advance the model by one clock edge; lock seen by the design lags the pin by two edges
    task automatic model_edge(input logic lk, input logic fr);
        int ls;
        ls = hist[0];
        hist.push_back(int'(lk));
        void'(hist.pop_front());
        case (m_phase)
            PH_RST: begin
                m_el++;
                if (m_el == RST_PULSE) model_enter(PH_WAIT);
            end
            PH_WAIT: begin
                m_el++;
                m_run = (ls != 0) ? m_run + 1 : 0;
                if (m_run == LOCK_FILTER) model_enter(PH_REL);
                else if (m_el == TIMEOUT) begin
                    if (m_retry == MAX_RETRY) model_enter(PH_FAIL);
                    else begin
                        m_retry++;
                        model_enter(PH_RST);
                    end
                end
            end
            PH_REL, PH_RUN: begin
                if (ls == 0 || fr) begin
                    if (ls == 0 && m_lost < 255) m_lost++;
                    model_enter(PH_RST);
                end else if (m_phase == PH_REL) begin
                    if (m_el == (NUM_DOMAINS - 1) * STAGGER) begin
                        m_retry = 0;
                        model_enter(PH_RUN);
                    end else m_el++;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [13:0] model_exp();
        logic [NUM_DOMAINS-1:0] dom;
        for (int i = 0; i < NUM_DOMAINS; i++)
            dom[i] = (m_phase == PH_REL) ? (m_el < i * STAGGER) : (m_phase != PH_RUN);
        return {m_phase == PH_RST, dom, m_phase == PH_RUN, m_phase == PH_FAIL,
                CNT_EN ? 8'(m_lost) : 8'd0};
    endfunction

    task automatic tick(input logic lk, input logic fr);
        pll_locked = lk;
        force_relock = fr;
        @(posedge clock);
        model_edge(lk, fr);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pll_locked = 1'b0;
        force_relock = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        pll_locked = 1'b1;
        force_relock = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (obs !== RESET_VAL) begin
            n_bad++;
            $display("[TB] FAIL reset_held: got %b, want %b", obs, RESET_VAL);
        end
        pll_locked = 1'b0;
        force_relock = 1'b0;
        model_reset();
        reset = 1'b0;
        n_cmp++;
        if (obs !== RESET_VAL) begin
            n_bad++;
            $display("[TB] FAIL reset_release: got %b, want %b", obs, RESET_VAL);
        end
    endtask

    // Lock appears once pll_rst drops: 2 sync cycles plus 8 filter cycles before domain 0 goes
    task automatic test_clean_start();
        int t_pll = -1, t_d0 = -1, t_d1 = -1, t_d2 = -1, t_rdy = -1;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            tick(n >= 5, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL clean_start cyc %0d: got %b, want %b", n, obs, model_exp());
            end
            if (t_pll < 0 && pll_rst === 1'b0) t_pll = n;
            if (t_d0 < 0 && domain_rst[0] === 1'b0) t_d0 = n;
            if (t_d1 < 0 && domain_rst[1] === 1'b0) t_d1 = n;
            if (t_d2 < 0 && domain_rst[2] === 1'b0) t_d2 = n;
            if (t_rdy < 0 && all_ready === 1'b1) t_rdy = n;
        end
        n_cmp++;
        if (t_pll != 4) begin n_bad++; $display("[TB] FAIL clean_pll_rst_end: got %0d, want 4", t_pll); end
        n_cmp++;
        if (t_d0 != 14) begin n_bad++; $display("[TB] FAIL clean_dom0_fall: got %0d, want 14", t_d0); end
        n_cmp++;
        if (t_d1 != 18) begin n_bad++; $display("[TB] FAIL clean_dom1_fall: got %0d, want 18", t_d1); end
        n_cmp++;
        if (t_d2 != 22) begin n_bad++; $display("[TB] FAIL clean_dom2_fall: got %0d, want 22", t_d2); end
        n_cmp++;
        if (t_rdy != 23) begin n_bad++; $display("[TB] FAIL clean_all_ready: got %0d, want 23", t_rdy); end
    endtask

    task automatic test_glitchy_lock();
        int t_d0 = -1;
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            tick((n >= 5 && n <= 10) || n >= 12, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL glitch cyc %0d: got %b, want %b", n, obs, model_exp());
            end
            if (t_d0 < 0 && domain_rst[0] === 1'b0) t_d0 = n;
        end
        n_cmp++;
        if (t_d0 != 21) begin n_bad++; $display("[TB] FAIL glitch_dom0_fall: got %0d, want 21", t_d0); end
    endtask

    task automatic test_lock_loss();
        int pulse_len = 0;
        do_reset();
        for (int n = 1; n <= 70; n++) begin
            tick(n >= 5 && n != 31, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL lock_loss cyc %0d: got %b, want %b", n, obs, model_exp());
            end
            if (n >= 31 && pll_rst === 1'b1) pulse_len++;
            if (n == 33) begin
                n_cmp++;
                if ({domain_rst, all_ready} !== 4'b1110) begin
                    n_bad++;
                    $display("[TB] FAIL lock_loss_drop: got %b, want 1110", {domain_rst, all_ready});
                end
            end
        end
        n_cmp++;
        if (pulse_len != 4) begin n_bad++; $display("[TB] FAIL lock_loss_pulse: got %0d, want 4", pulse_len); end
        n_cmp++;
        if (lock_lost_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            n_bad++;
            $display("[TB] FAIL lock_loss_cnt: got %0d, want %0d", lock_lost_cnt, CNT_EN ? 1 : 0);
        end
        n_cmp++;
        if (all_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL lock_loss_rerun: got %b, want 1", all_ready); end
    endtask

    // Force at 31 alone, then force together with a real loss at edge 77 (counted once)
    task automatic test_force_relock();
        do_reset();
        for (int n = 1; n <= 110; n++) begin
            tick(n >= 5 && n != 75, n == 31 || n == 77);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL force cyc %0d: got %b, want %b", n, obs, model_exp());
            end
            if (n == 31) begin
                n_cmp++;
                if ({pll_rst, domain_rst, all_ready} !== 5'b11110) begin
                    n_bad++;
                    $display("[TB] FAIL force_drop: got %b, want 11110", {pll_rst, domain_rst, all_ready});
                end
            end
            if (n == 76) begin
                n_cmp++;
                if (lock_lost_cnt !== 8'd0) begin
                    n_bad++;
                    $display("[TB] FAIL force_no_count: got %0d, want 0", lock_lost_cnt);
                end
            end
        end
        n_cmp++;
        if (lock_lost_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            n_bad++;
            $display("[TB] FAIL force_loss_once: got %0d, want %0d", lock_lost_cnt, CNT_EN ? 1 : 0);
        end
        n_cmp++;
        if (all_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL force_rerun: got %b, want 1", all_ready); end
    endtask

    task automatic test_timeout_fail();
        int pulses = 1, t_fail = -1;
        logic prev = 1'b1;
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            tick(n > 210, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL timeout cyc %0d: got %b, want %b", n, obs, model_exp());
            end
            if (pll_rst === 1'b1 && prev === 1'b0) pulses++;
            prev = pll_rst;
            if (t_fail < 0 && fail === 1'b1) t_fail = n;
        end
        n_cmp++;
        if (pulses != 3) begin n_bad++; $display("[TB] FAIL timeout_pulses: got %0d, want 3", pulses); end
        n_cmp++;
        if (t_fail != 204) begin n_bad++; $display("[TB] FAIL timeout_fail_at: got %0d, want 204", t_fail); end
        n_cmp++;
        if ({fail, pll_rst, domain_rst, all_ready} !== 6'b101110) begin
            n_bad++;
            $display("[TB] FAIL timeout_stuck: got %b, want 101110", {fail, pll_rst, domain_rst, all_ready});
        end
    endtask

    task automatic test_reset_during_release();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            tick(n >= 5, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL pre_reset cyc %0d: got %b, want %b", n, obs, model_exp());
            end
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (obs !== RESET_VAL) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got %b, want %b", obs, RESET_VAL);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs !== model_exp()) begin
                n_bad++;
                $display("[TB] FAIL post_reset cyc %0d: got %b, want %b", n, obs, model_exp());
            end
        end
    endtask

    task automatic test_random();
        int drops[6] = '{0, 1, 3, 10, 30, 100};
        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int n = 1; n <= 250; n++) begin
                tick($urandom_range(99) >= drops[s], $urandom_range(199) == 0);
                n_cmp++;
                if (obs !== model_exp()) begin
                    n_bad++;
                    $display("[TB] FAIL random seg %0d cyc %0d: got %b, want %b", s, n, obs, model_exp());
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_clean_start();
        test_glitchy_lock();
        test_lock_loss();
        test_force_relock();
        test_timeout_fail();
        test_reset_during_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
